// File: rtl/inv_mask_pkg.sv
// Shared types and helpers for the selective-inversion scheduler.
package inv_mask_pkg;

  typedef enum logic [1:0] {
    PASS = 2'b00,
    EVEN = 2'b01,
    ALL  = 2'b10,
    WALK = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;

  localparam int MaxWidth = 64;

  // Widest even-bit pattern; callers slice off the low n bits they need.
  function automatic logic [MaxWidth-1:0] even_mask(input int n);
    logic [MaxWidth-1:0] m;
    m = '0;
    for (int i = 0; i < MaxWidth; i++) begin
      if (i < n && (i % 2) == 0) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/mask_inv.sv
// Pure combinational inverter slice: each output bit is x flipped where m is set.
module mask_inv #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] m,
  output logic [N-1:0] y
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign y[i] = x[i] ^ m[i];
  end

endmodule

// File: rtl/inv_mask_scheduler.sv
// Burst scheduler driving mask_inv with a mode-generated mask over valid/ready links.
// Optional registered PARITY output when INV_MASK_SCHEDULER_PARITY_EN is defined.
module inv_mask_scheduler
  import inv_mask_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] count,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  y,
  output logic [N-1:0]  mask,
  output logic          busy,
  output logic          done
`ifdef INV_MASK_SCHEDULER_PARITY_EN
  ,
  output logic          parity
`endif
);

  localparam logic [MaxWidth-1:0] EvenFull = even_mask(N);
  localparam logic [N-1:0]        EvenMask = EvenFull[N-1:0];
  localparam logic [N-1:0]        WalkSeed = {{(N-1){1'b0}}, 1'b1};

  state_t        state, next_state;
  mode_t         mode_q;
  logic [CW-1:0] remaining;
  logic          accept_start, xfer, consume;
  logic [N-1:0]  start_mask, inv_word;

  mask_inv #(.N(N)) u_inv (
    .x (x),
    .m (mask),
    .y (inv_word)
  );

  always_comb begin
    start_mask = '0;
    case (mode_t'(mode))
      PASS:    start_mask = '0;
      EVEN:    start_mask = EvenMask;
      ALL:     start_mask = '1;
      WALK:    start_mask = WalkSeed;
      default: start_mask = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    in_ready     = 1'b0;
    accept_start = 1'b0;
    xfer         = 1'b0;
    consume      = out_valid && out_ready;
    case (state)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          if (count != '0) next_state = RUN;
        end
      end
      RUN: begin
        in_ready = !out_valid || out_ready;
        xfer     = in_valid && in_ready;
        if (xfer && remaining == CW'(1)) next_state = DRAIN;
      end
      DRAIN: begin
        if (consume) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // A zero-length burst still reports completion, one cycle after START.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= PASS;
      remaining <= '0;
      mask      <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
`ifdef INV_MASK_SCHEDULER_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept_start) begin
        mode_q    <= mode_t'(mode);
        remaining <= count;
        mask      <= start_mask;
        if (count == '0) done <= 1'b1;
      end
      if (xfer) begin
        y         <= inv_word;
        out_valid <= 1'b1;
        remaining <= remaining - CW'(1);
`ifdef INV_MASK_SCHEDULER_PARITY_EN
        parity    <= ^inv_word;
`endif
        if (mode_q == WALK) mask <= {mask[N-2:0], mask[N-1]};
      end else if (consume) begin
        out_valid <= 1'b0;
      end
      if (state == DRAIN && consume) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inv_mask_scheduler.sv
// Randomized bench for inv_mask_scheduler with a word-level reference model and directed literal bursts.
module tb_inv_mask_scheduler;

  localparam int N  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [CW-1:0] count = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  x = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  y;
  logic [N-1:0]  mask;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  inv_mask_scheduler #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .count     (count),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .mask      (mask),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference model: a burst is a number of words still to accept plus a
  // queue of produced-but-unconsumed words; the mask is a function of word index.
  bit           m_active = 1'b0;
  bit           m_done = 1'b0;
  int           m_left = 0;
  int           m_idx = 0;
  logic [1:0]   m_mode = 2'b00;
  logic [N-1:0] m_y = '0;
  logic [N-1:0] m_mask = '0;
  logic [N-1:0] m_outq[$];
  bit           m_consume, m_xfer;

  function automatic logic [N-1:0] maskFor(input logic [1:0] md, input int k);
    case (md)
      2'b00:   return 4'b0000;
      2'b01:   return 4'b0101;
      2'b10:   return 4'b1111;
      default: return 4'b0001 << (k % N);
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_left   = 0;
      m_idx    = 0;
      m_mode   = 2'b00;
      m_y      = '0;
      m_mask   = '0;
      m_outq.delete();
    end else begin
      m_consume = (m_outq.size() > 0) && out_ready;
      m_done = 1'b0;
      if (!m_active) begin
        if (start) begin
          m_mode = mode;
          m_idx  = 0;
          m_left = int'(count);
          m_mask = maskFor(mode, 0);
          if (count == 0) m_done = 1'b1;
          else            m_active = 1'b1;
        end
      end else begin
        m_xfer = (m_left > 0) && (m_outq.size() == 0 || out_ready) && in_valid;
        if (m_consume) void'(m_outq.pop_front());
        if (m_xfer) begin
          m_y = x ^ maskFor(m_mode, m_idx);
          m_outq.push_back(m_y);
          m_idx++;
          m_left--;
          m_mask = maskFor(m_mode, m_idx);
        end else if (m_consume && m_left == 0) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("in_ready",  8'(in_ready),
                8'(m_active && m_left > 0 && (m_outq.size() == 0 || out_ready)));
    checkOutput("out_valid", 8'(out_valid), 8'(m_outq.size() > 0));
    checkOutput("y",         8'(y),         8'(m_y));
    checkOutput("mask",      8'(mask),      8'(m_mask));
    checkOutput("busy",      8'(busy),      8'(m_active));
    checkOutput("done",      8'(done),      8'(m_done));
  end

  logic [N-1:0] got[$];
  logic [N-1:0] exp[$];
  logic [N-1:0] words[$];
  int doneCnt = 0;
  int ovCnt = 0;
  int busyCnt = 0;

  always @(negedge clk) begin
    if (out_valid && out_ready) got.push_back(y);
    if (done) doneCnt++;
    if (out_valid) ovCnt++;
    if (busy) busyCnt++;
  end

  task automatic checkSeq(input string name);
    checkOutput({name, "_len"}, 8'(got.size()), 8'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      checkOutput(name, 8'(got[i]), 8'(exp[i]));
  endtask

  // flow: 0 = always ready, 1 = random handshakes, 2 = three-cycle sink stall on first word.
  task automatic applyStimulus(input logic [1:0] md, input int cnt, input int flow, input bit poke);
    int widx = 0;
    int cyc = 0;
    int stall = 0;
    bit acc = 1'b0;
    bit seenDone = 1'b0;
    bit stalled = 1'b0;
    @(posedge clk); #2;
    start = 1'b1; mode = md; count = CW'(cnt); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; mode = 2'($urandom); count = CW'($urandom);
    x = (words.size() > 0) ? words[0] : N'($urandom);
    in_valid  = (flow == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    out_ready = (flow == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    while (cyc < 300) begin
      @(negedge clk);
      if (done) seenDone = 1'b1;
      acc = in_valid && in_ready;
      if (seenDone) break;
      @(posedge clk); #2;
      cyc++;
      if (acc) widx++;
      x = (widx < words.size()) ? words[widx] : N'($urandom);
      if (flow == 2 && acc && !stalled) begin
        stalled = 1'b1;
        stall = 3;
      end
      in_valid = (flow == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (flow == 1)      out_ready = 1'($urandom_range(0, 1));
      else if (stall > 0) begin out_ready = 1'b0; stall--; end
      else                out_ready = 1'b1;
      if (poke && cyc == 2 && m_active) begin
        start = 1'b1; mode = ~md; count = CW'($urandom_range(1, 9));
      end else begin
        start = 1'b0;
      end
    end
    if (!seenDone) begin
      checks++;
      errors++;
      $display("[TB] FAIL burst_timeout: got no done expected done within 300 cycles");
    end
    #1;
    in_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
    words.delete();
  endtask

  int d0, ov0, b0;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_out_valid", 8'(out_valid), 8'h0);
    checkOutput("rst_y",         8'(y),         8'h0);
    checkOutput("rst_mask",      8'(mask),      8'h0);
    checkOutput("rst_busy",      8'(busy),      8'h0);
    reset = 1'b0;

    // Even-bit mask over three words
    got.delete();
    words = {4'b0000, 4'b1111, 4'b1010};
    d0 = doneCnt;
    applyStimulus(2'b01, 3, 0, 1'b0);
    exp = {4'b0101, 4'b1010, 4'b1111};
    checkSeq("even_burst");
    checkOutput("even_done_once", 8'(doneCnt - d0), 8'd1);

    // Walking one wraps from MSB back to bit 0
    got.delete();
    words = {4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    applyStimulus(2'b11, 5, 0, 1'b0);
    exp = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    checkSeq("walk_burst");

    // Sink stall holds the first word; nothing lost or duplicated
    got.delete();
    words = {4'b0011, 4'b0110};
    applyStimulus(2'b10, 2, 2, 1'b0);
    exp = {4'b1100, 4'b1001};
    checkSeq("stall_burst");

    // Zero-length burst: only a done pulse
    d0 = doneCnt; ov0 = ovCnt; b0 = busyCnt;
    applyStimulus(2'b10, 0, 0, 1'b0);
    checkOutput("zero_done_once", 8'(doneCnt - d0), 8'd1);
    checkOutput("zero_no_valid",  8'(ovCnt - ov0),  8'd0);
    checkOutput("zero_no_busy",   8'(busyCnt - b0), 8'd0);

    // START while busy with another mode is ignored
    got.delete();
    words = {4'b1001, 4'b0110, 4'b1111};
    applyStimulus(2'b00, 3, 0, 1'b1);
    exp = {4'b1001, 4'b0110, 4'b1111};
    checkSeq("poke_burst");

    // Asynchronous reset mid-burst with a word pending
    @(posedge clk); #2;
    start = 1'b1; mode = 2'b10; count = 8'd5; in_valid = 1'b1; x = 4'b0011; out_ready = 1'b0;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    checkOutput("pre_rst_valid", 8'(out_valid), 8'h1);
    reset = 1'b1;
    #1;
    checkOutput("arst_in_ready",  8'(in_ready),  8'h0);
    checkOutput("arst_out_valid", 8'(out_valid), 8'h0);
    checkOutput("arst_y",         8'(y),         8'h0);
    checkOutput("arst_mask",      8'(mask),      8'h0);
    checkOutput("arst_busy",      8'(busy),      8'h0);
    checkOutput("arst_done",      8'(done),      8'h0);
    @(posedge clk); #2;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    got.delete();
    words = {4'b1111, 4'b1111, 4'b0000};
    applyStimulus(2'b11, 3, 0, 1'b0);
    exp = {4'b1110, 4'b1101, 4'b0100};
    checkSeq("post_reset_walk");

    // Randomized bursts against the model
    for (int i = 0; i < 40; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), $urandom_range(0, 9),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (2) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: got still running expected finished");
    $fatal(1, "[TB] global timeout");
  end

endmodule
